// File: rtl/dc_commutator_stage_pkg.sv
// Shared constants and width helpers for the delay-commutator stage.
// Keeps the counter-width rule in one place so every lane agrees on it.
package dc_commutator_stage_pkg;

    localparam int DC_NBITS_DEFAULT = 15;
    localparam int DC_DELAY_DEFAULT = 16;

    // Counter spans 2*DELAY accepted samples; its MSB is the swap select.
    function automatic int dc_cnt_width(input int delay);
        return $clog2(delay) + 1;
    endfunction

endpackage

// File: rtl/dc_commutator_stage_delay_line.sv
// Enabled shift register: q is the input seen DEPTH accepted samples ago.
// Every cell clears on reset so the first DEPTH outputs read as zero.
module dc_delay_line
    import dc_commutator_stage_pkg::*;
#(
    parameter int WIDTH = 30,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] cells [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cells[i] <= '0;
            end
        end else if (en) begin
            cells[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                cells[i] <= cells[i-1];
            end
        end
    end

    assign q = cells[DEPTH-1];

endmodule

// File: rtl/dc_commutator_stage.sv
// Delay commutator for one lane of a radix-2^2 pipeline: reorders the up/down
// streams so the next butterfly sees pairs DELAY samples apart. No arithmetic.
module dc_commutator_stage
    import dc_commutator_stage_pkg::*;
#(
    parameter int NBITS = DC_NBITS_DEFAULT,
    parameter int DELAY = DC_DELAY_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_enable,
    input  logic [2*NBITS-1:0] in_up,
    input  logic [2*NBITS-1:0] in_down,
    output logic [2*NBITS-1:0] out_up,
    output logic [2*NBITS-1:0] out_down,
    output logic               o_enable
);

    localparam int CW   = 2 * NBITS;
    localparam int CNTW = dc_cnt_width(DELAY);
    localparam logic [CNTW-1:0] FILL_FULL = CNTW'(DELAY);

    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] fill;
    logic            swap;
    logic            fill_done;
    logic [CW-1:0]   dly_dn;
    logic [CW-1:0]   dly_up;
    logic [CW-1:0]   to_up;
    logic [CW-1:0]   pre_dn;

    // Natural wrap of a CNTW-bit counter is exactly modulo 2*DELAY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (i_enable) begin
            cnt <= cnt + CNTW'(1);
        end
    end

    assign swap = cnt[CNTW-1];

    dc_delay_line #(
        .WIDTH (CW),
        .DEPTH (DELAY)
    ) u_dly_dn (
        .clk (clk),
        .rst (rst),
        .en  (i_enable),
        .d   (in_down),
        .q   (dly_dn)
    );

    always_comb begin
        to_up  = in_up;
        pre_dn = dly_dn;
        if (swap) begin
            to_up  = dly_dn;
            pre_dn = in_up;
        end
    end

    dc_delay_line #(
        .WIDTH (CW),
        .DEPTH (DELAY)
    ) u_dly_up (
        .clk (clk),
        .rst (rst),
        .en  (i_enable),
        .d   (to_up),
        .q   (dly_up)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_up   <= '0;
            out_down <= '0;
        end else if (i_enable) begin
            out_up   <= dly_up;
            out_down <= pre_dn;
        end
    end

    assign fill_done = (fill == FILL_FULL);

    // o_enable latches on the first accepted sample after the lines are full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill     <= '0;
            o_enable <= 1'b0;
        end else if (i_enable) begin
            if (!fill_done) begin
                fill <= fill + CNTW'(1);
            end else begin
                o_enable <= 1'b1;
            end
        end
    end

endmodule
